// File: rtl/dds_pkg.sv
// Shared defaults, unity-gain helper and shadow-configuration struct for dds_sine_gen.
// The struct fields are sized from the package default widths.
package dds_pkg;

  localparam int DDS_DATA_W  = 16;
  localparam int DDS_PHASE_W = 32;
  localparam int DDS_LUT_AW  = 10;
  localparam int DDS_AMP_W   = 16;

  // Unity gain for an unsigned gain word of amp_w bits.
  function automatic int unsigned AMP_ONE(input int unsigned amp_w);
    return 32'd1 << (amp_w - 1);
  endfunction

  typedef struct packed {
    logic        [DDS_PHASE_W-1:0] freq;
    logic        [DDS_PHASE_W-1:0] phase_off;
    logic        [DDS_AMP_W-1:0]   amp;
    logic signed [DDS_DATA_W-1:0]  dc_off;
  } dds_cfg_t;

endpackage

// File: rtl/sine_lut.sv
// Sine table with a registered read (1-cycle latency). Define DDS_QUARTER_WAVE_LUT_EN
// to store only the first quadrant and rebuild the full wave by mirroring/negation.
module sine_lut #(
  parameter int LUT_AW = 10,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LUT_AW-1:0]        addr,
  output logic signed [DATA_W-1:0] data
);

  localparam real PI = 3.14159265358979323846;
`ifdef DDS_QUARTER_WAVE_LUT_EN
  localparam int N_ENT = (1 << (LUT_AW - 2)) + 1;
`else
  localparam int N_ENT = 1 << LUT_AW;
`endif

  // Entry k = round(sin(2*pi*k/2^LUT_AW) * (2^(DATA_W-1)-1)), halves rounded away from zero.
  function automatic logic signed [DATA_W-1:0] sine_entry(input int k);
    real v;
    v = $sin(2.0 * PI * real'(k) / real'(1 << LUT_AW)) * real'((1 << (DATA_W - 1)) - 1);
    if (v >= 0.0) return DATA_W'($rtoi(v + 0.5));
    else          return DATA_W'(-$rtoi(0.5 - v));
  endfunction

  logic signed [DATA_W-1:0] rom_w [N_ENT];
  logic signed [DATA_W-1:0] data_d, data_q;

  for (genvar k = 0; k < N_ENT; k++) begin : g_rom
    assign rom_w[k] = sine_entry(k);
  end

`ifdef DDS_QUARTER_WAVE_LUT_EN
  localparam logic [LUT_AW-2:0] Q_END = (LUT_AW-1)'(1 << (LUT_AW - 2));

  logic [1:0]               quad;
  logic [LUT_AW-2:0]        idx;
  logic signed [DATA_W-1:0] mag;

  // Odd quadrants read the table backwards; the second half-period is negated.
  always_comb begin
    quad   = addr[LUT_AW-1 -: 2];
    idx    = {1'b0, addr[LUT_AW-3:0]};
    if (quad[0]) idx = Q_END - idx;
    mag    = rom_w[idx];
    data_d = quad[1] ? -mag : mag;
  end
`else
  always_comb begin
    data_d = rom_w[addr];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/dds_sine_gen.sv
// DDS sine generator: shadowed config, phase accumulator and a 4-stage lookup/scale/shift
// pipeline. Build option DDS_QUARTER_WAVE_LUT_EN selects a quarter-wave table in sine_lut.
module dds_sine_gen
  import dds_pkg::*;
#(
  parameter int DATA_W  = DDS_DATA_W,
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int LUT_AW  = DDS_LUT_AW,
  parameter int AMP_W   = DDS_AMP_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      sync_clr,
  input  logic                      cfg_load,
  input  logic [PHASE_W-1:0]        freq_word,
  input  logic [PHASE_W-1:0]        phase_off,
  input  logic [AMP_W-1:0]          amp,
  input  logic signed [DATA_W-1:0]  dc_off,
  output logic signed [DATA_W-1:0]  sine_out,
  output logic signed [DATA_W:0]    shifted_out,
  output logic                      out_valid
);

  localparam logic [AMP_W-1:0] AMP_UNITY = AMP_W'(AMP_ONE(AMP_W));
  localparam int               PROD_W    = DATA_W + AMP_W + 1;

  dds_cfg_t                 cfg_d, cfg_q;
  logic [PHASE_W-1:0]       acc_d, acc_q;
  logic [PHASE_W-1:0]       phase_w;
  logic [LUT_AW-1:0]        addr_d, addr_q;
  logic signed [DATA_W-1:0] lut_w;
  logic signed [PROD_W-1:0] prod_w;
  logic signed [DATA_W-1:0] s3_d, s3_q;
  logic signed [DATA_W-1:0] sine_d, sine_q;
  logic signed [DATA_W:0]   shift_d, shift_q;
  logic [3:0]               vld_d, vld_q;
  logic                     unused_phase_bits;
  logic                     unused_prod_bits;

  // No back-pressure: en marks the sample launched this cycle as valid, and out_valid
  // qualifies the outputs exactly four cycles later; the consumer must take every sample.
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_load) begin
      cfg_d.freq      = freq_word;
      cfg_d.phase_off = phase_off;
      cfg_d.amp       = (amp > AMP_UNITY) ? AMP_UNITY : amp;
      cfg_d.dc_off    = dc_off;
    end

    if (sync_clr) acc_d = '0;
    else if (en)  acc_d = acc_q + cfg_q.freq;
    else          acc_d = acc_q;

    phase_w           = acc_q + cfg_q.phase_off;
    addr_d            = phase_w[PHASE_W-1 -: LUT_AW];
    unused_phase_bits = ^phase_w[PHASE_W-LUT_AW-1:0];

    // Bits [AMP_W-1 +: DATA_W] of the product are product >>> (AMP_W-1), floor-rounded.
    prod_w           = PROD_W'(lut_w) * PROD_W'($signed({1'b0, cfg_q.amp}));
    s3_d             = prod_w[AMP_W-1 +: DATA_W];
    unused_prod_bits = ^{prod_w[PROD_W-1 -: 2], prod_w[AMP_W-2:0]};

    sine_d  = s3_q;
    shift_d = {s3_q[DATA_W-1], s3_q} + {cfg_q.dc_off[DATA_W-1], cfg_q.dc_off};
    vld_d   = {vld_q[2:0], en};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= '{freq: '0, phase_off: '0, amp: AMP_UNITY, dc_off: '0};
      acc_q   <= '0;
      addr_q  <= '0;
      s3_q    <= '0;
      sine_q  <= '0;
      shift_q <= '0;
      vld_q   <= '0;
    end else begin
      cfg_q   <= cfg_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      s3_q    <= s3_d;
      sine_q  <= sine_d;
      shift_q <= shift_d;
      vld_q   <= vld_d;
    end
  end

  sine_lut #(
    .LUT_AW (LUT_AW),
    .DATA_W (DATA_W)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr_q),
    .data  (lut_w)
  );

  assign sine_out    = sine_q;
  assign shifted_out = shift_q;
  assign out_valid   = vld_q[3];

endmodule

// File: tb/tb_dds_sine_gen.sv
// Directed bench for dds_sine_gen: a per-cycle expected queue driven alongside the stimulus
// and checked four cycles later, plus directed value checks on captured output samples.
module tb_dds_sine_gen;

  localparam real PI = 3.14159265358979323846;

  logic               clk, rst_n, en, sync_clr, cfg_load;
  logic [31:0]        freq_word, phase_off;
  logic [15:0]        amp;
  logic signed [15:0] dc_off;
  logic signed [15:0] sine_out;
  logic signed [16:0] shifted_out;
  logic               out_valid;

  int                 n_assert, n_fail;
  logic [33:0]        exp_q[$];
  logic signed [15:0] got_sine[$];
  logic signed [16:0] got_shift[$];
  int                 ref_tab[1024];
  int unsigned        acc_m, freq_m, poff_m;
  int                 amp_m, dc_m;
  longint             mx, mn;

  dds_sine_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync_clr    (sync_clr),
    .cfg_load    (cfg_load),
    .freq_word   (freq_word),
    .phase_off   (phase_off),
    .amp         (amp),
    .dc_off      (dc_off),
    .sine_out    (sine_out),
    .shifted_out (shifted_out),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Expected entry {valid, sine, shifted} for a sample launched with the current model state.
  function automatic logic [33:0] model_entry(input logic e);
    int unsigned ph;
    int          addr_i;
    longint      prod, s, sh;
    ph     = acc_m + poff_m;
    addr_i = int'(ph >> 22);
    prod   = longint'(ref_tab[addr_i]) * longint'(amp_m);
    s      = prod >>> 15;
    sh     = s + longint'(dc_m);
    return {e, s[15:0], sh[16:0]};
  endfunction

  task automatic check_out();
    logic [33:0] e;
    if (exp_q.size() == 4) begin
      e = exp_q.pop_front();
      chk("out_valid", out_valid, e[33]);
      if (e[33]) begin
        chk("sine_out", sine_out, $signed(e[32:17]));
        chk("shifted_out", shifted_out, $signed(e[16:0]));
        got_sine.push_back(sine_out);
        got_shift.push_back(shifted_out);
      end
    end
  endtask

  task automatic step(input logic e, input logic clr);
    @(negedge clk);
    check_out();
    en       = e;
    sync_clr = clr;
    cfg_load = 1'b0;
    exp_q.push_back(model_entry(e));
    if (clr)    acc_m = 0;
    else if (e) acc_m = acc_m + freq_m;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic load(input int unsigned f, input int unsigned p, input int a, input int d);
    @(negedge clk);
    check_out();
    en        = 1'b0;
    sync_clr  = 1'b0;
    cfg_load  = 1'b1;
    freq_word = f;
    phase_off = p;
    amp       = 16'(a);
    dc_off    = 16'(d);
    exp_q.push_back(model_entry(1'b0));
    freq_m = f;
    poff_m = p;
    amp_m  = (a > 32768) ? 32768 : a;
    dc_m   = d;
  endtask

  // Drain, load a new configuration, clear the accumulator and forget earlier captures.
  task automatic start(input int unsigned f, input int unsigned p, input int a, input int d);
    idle(5);
    load(f, p, a, d);
    step(1'b0, 1'b1);
    got_sine.delete();
    got_shift.delete();
  endtask

  task automatic sine_extremes();
    mx = -100000;
    mn = 100000;
    foreach (got_sine[i]) begin
      if (got_sine[i] > mx) mx = got_sine[i];
      if (got_sine[i] < mn) mn = got_sine[i];
    end
  endtask

  task automatic shift_extremes();
    mx = -100000;
    mn = 100000;
    foreach (got_shift[i]) begin
      if (got_shift[i] > mx) mx = got_shift[i];
      if (got_shift[i] < mn) mn = got_shift[i];
    end
  endtask

  initial begin
    real v;
    n_assert = 0;
    n_fail   = 0;
    for (int k = 0; k < 1024; k++) begin
      v = $sin(2.0 * PI * real'(k) / 1024.0) * 32767.0;
      ref_tab[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    end
    acc_m = 0; freq_m = 0; poff_m = 0; amp_m = 32768; dc_m = 0;

    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; cfg_load = 1'b0;
    freq_word = '0; phase_off = '0; amp = '0; dc_off = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_sine", sine_out, 0);
    chk("reset_shifted", shifted_out, 0);
    rst_n = 1'b1;

    // Unit step through one full period and past the wrap.
    start(32'h0040_0000, 0, 32'h8000, 0);
    run(1030);
    idle(4);
    chk("s1_count", got_sine.size(), 1030);
    chk("s1_sample0", got_sine[0], 0);
    chk("s1_sample1", got_sine[1], 201);
    chk("s1_sample2", got_sine[2], 402);
    chk("s1_sample256", got_sine[256], 32767);
    chk("s1_sample768", got_sine[768], -32767);
    chk("s1_sample1024", got_sine[1024], 0);

    // Half gain, then an over-range gain that must clamp to unity.
    start(32'h0040_0000, 0, 32'h4000, 0);
    run(1024);
    idle(4);
    sine_extremes();
    chk("half_amp_peak", mx, 16383);
    chk("half_amp_trough", mn, -16384);
    start(32'h0040_0000, 0, 32'hFFFF, 0);
    run(260);
    idle(4);
    chk("clamp_peak", got_sine[256], 32767);

    // Quarter-period phase offset.
    start(32'h0040_0000, 32'h4000_0000, 32'h8000, 0);
    run(4);
    idle(4);
    chk("phase_off_first", got_sine[0], 32767);

    // Most negative DC shift at unity gain.
    start(32'h0040_0000, 0, 32'h8000, -32768);
    run(1024);
    idle(4);
    chk("dc_sample768", got_shift[768], -65535);
    chk("dc_sample256", got_shift[256], -1);
    shift_extremes();
    chk("dc_max", mx, -1);
    chk("dc_min", mn, -65535);

    // Enable gaps: bubbles in out_valid, consecutive addresses in the valid samples.
    start(32'h0040_0000, 0, 32'h8000, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(4);
    chk("gap_count", got_sine.size(), 2);
    chk("gap_second", got_sine[1], 201);

    // Asynchronous reset in the middle of a stream.
    start(32'h0040_0000, 0, 32'h8000, 0);
    run(300);
    #2;
    chk("pre_reset_valid", out_valid, 1);
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sine", sine_out, 0);
    chk("async_rst_shifted", shifted_out, 0);
    exp_q.delete();
    acc_m = 0; freq_m = 0; poff_m = 0; amp_m = 32768; dc_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    got_sine.delete();
    got_shift.delete();
    run(10);
    idle(4);
    chk("post_rst_count", got_sine.size(), 10);
    chk("post_rst_sine", got_sine[9], 0);
    chk("post_rst_shifted", got_shift[9], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
